store_pixel_block: RTL and testbench
====================================

STORE_PIXEL_BLOCK -- requirements
Module: store_pixel_block

Interface
REQ-001 Parameter: PIXEL_W, default 9, pixel word width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to write one block; sampled only in IDLE.
REQ-006 block_x  input  8  block column index; one block is 8 memory pixels wide.
REQ-007 block_y  input  8  block row index; one block is 8 memory pixels tall.
REQ-008 pixels  input  16*PIXEL_W  sixteen packed pixels; pixel n occupies bits [n*PIXEL_W +: PIXEL_W], row-major 4x4 (n = 4*row + col).
REQ-009 mem_ready  input  1  memory accepts the presented write this cycle.
REQ-010 mem_hcount  output  10  write column address.
REQ-011 mem_vcount  output  10  write row address.
REQ-012 mem_data  output  PIXEL_W  write data.
REQ-013 mem_we  output  1  write request; a write completes when mem_we and mem_ready are both 1.
REQ-014 busy  output  1  high in WRITE state.
REQ-015 done  output  1  one-cycle pulse after the final write completes.

Function
REQ-016 States SHALL be IDLE, WRITE and DONE.
REQ-017 IDLE with start=1 SHALL latch pixels, block_x and block_y, clear x_cnt and y_cnt (3 bits each), and enter WRITE; start=0 SHALL stay in IDLE.
REQ-018 In WRITE: mem_we=1; mem_hcount = {block_x,3'b000} + x_cnt, truncated to 10 bits; mem_vcount = {block_y,3'b000} + y_cnt, truncated to 10 bits.
REQ-019 mem_data SHALL be latched pixel index 4*(y_cnt>>1) + (x_cnt>>1); each source pixel is replicated into a 2x2 memory square.
REQ-020 Write order SHALL be raster: x_cnt 0..7 within a row, then y_cnt increments; 64 writes per block.
REQ-021 While mem_ready=0 in WRITE, counters, address and data SHALL hold unchanged.
REQ-022 When the write at x_cnt=7, y_cnt=7 completes, the block SHALL enter DONE; DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-023 start asserted in WRITE or DONE SHALL be ignored, and input changes in those states SHALL not affect the writes in progress.
REQ-024 Latency with mem_ready held at 1: start sampled at edge 0; first mem_we in cycle 1; last write in cycle 64; done in cycle 65; start accepted again from cycle 66.
REQ-025 Address overflow past 10 bits (block_x or block_y >= 128) SHALL wrap modulo 1024 with no error indication.
REQ-026 Outputs in IDLE and DONE: mem_we=0, busy=0, mem_hcount/mem_vcount/mem_data hold their last values.

Reset
REQ-027 reset=1 SHALL force IDLE, mem_we=0, busy=0, done=0, x_cnt=y_cnt=0, mem_hcount=0, mem_vcount=0, mem_data=0 at the next edge.
REQ-028 reset during WRITE SHALL abort the block: no further mem_we, and no done pulse for the aborted block.
REQ-029 reset SHALL take priority over start when both are asserted.

Verification
REQ-030 block_x=2, block_y=1, pixel n=n, mem_ready=1, pulse start -> 64 writes covering hcount 16..23 and vcount 8..15; address (17,9) carries data 0; address (18,8) carries data 1; address (23,15) carries data 15; done at cycle 65.
REQ-031 Same stimulus with mem_ready low on every other cycle -> identical address/data sequence, each value held until accepted; exactly 64 accepted writes; done one cycle after the last.
REQ-032 block_x=130, block_y=0 -> first mem_hcount = 1040 mod 1024 = 16.
REQ-033 start held high continuously -> blocks back-to-back with one IDLE cycle between the done pulse and the next first write; pixels changed during WRITE -> no effect on the current block.
REQ-034 reset asserted at the 10th write -> mem_we=0 at the next edge, no done pulse, and the next start restarts at x_cnt=0, y_cnt=0.

Source files
------------

// File: rtl/store_pixel_block.sv
// -----------------------------------------------------------------------------
// store_pixel_block
//
// Writes one 4x4 block of source pixels into a frame memory as an 8x8 square
// of memory pixels.  Each source pixel is replicated into a 2x2 memory square.
// Writes are issued in raster order (x 0..7 within a row, then the next row)
// with a simple valid/ready handshake: a write completes on a cycle where
// mem_we and mem_ready are both high.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   start       request to write one block (only looked at in IDLE)
//   block_x     block column index (8 memory pixels per block)
//   block_y     block row index (8 memory pixels per block)
//   pixels      16 packed pixels, pixel n at [n*PIXEL_W +: PIXEL_W],
//               row-major 4x4 (n = 4*row + col)
//   mem_ready   memory accepts the presented write this cycle
//   mem_hcount  write column address (wraps modulo 1024)
//   mem_vcount  write row address (wraps modulo 1024)
//   mem_data    write data
//   mem_we      write request
//   busy        high while writing a block
//   done        one-cycle pulse after the final write of a block completes
//
// States
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; outputs hold the last written values
//   S_WRITE | presenting writes, advancing on each accepted write
//   S_DONE  | block finished; done pulses for this one cycle
// -----------------------------------------------------------------------------
module store_pixel_block #(
  parameter int PIXEL_W = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             block_x,
  input  logic [7:0]             block_y,
  input  logic [16*PIXEL_W-1:0]  pixels,
  input  logic                   mem_ready,
  output logic [9:0]             mem_hcount,
  output logic [9:0]             mem_vcount,
  output logic [PIXEL_W-1:0]     mem_data,
  output logic                   mem_we,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [16*PIXEL_W-1:0] pix_q;
  logic [7:0]            bx_q;
  logic [7:0]            by_q;
  logic [2:0]            x_cnt;
  logic [2:0]            y_cnt;

  logic [2:0]            x_nxt;
  logic [2:0]            y_nxt;
  logic                  last_wr;

  // Memory address of offset o inside block b.  The 11-bit sum is cut to
  // 10 bits on purpose: block indices >= 128 wrap silently modulo 1024.
  function automatic logic [9:0] block_addr(input logic [7:0] b,
                                            input logic [2:0] o);
    return 10'({b, 3'b000} + 11'(o));
  endfunction

  // Source pixel idx = 4*row + col out of a packed 16-pixel word.
  function automatic logic [PIXEL_W-1:0] pixel_at(input logic [16*PIXEL_W-1:0] p,
                                                  input logic [3:0] idx);
    return p[int'(idx)*PIXEL_W +: PIXEL_W];
  endfunction

  always_comb begin
    x_nxt   = x_cnt + 3'd1;
    y_nxt   = (x_cnt == 3'd7) ? (y_cnt + 3'd1) : y_cnt;
    last_wr = (x_cnt == 3'd7) && (y_cnt == 3'd7);
  end

  // Address and data are registered so they can be held steady while the
  // memory stalls, and keep their last values once the block is finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pix_q      <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      mem_hcount <= '0;
      mem_vcount <= '0;
      mem_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pix_q      <= pixels;
            bx_q       <= block_x;
            by_q       <= block_y;
            x_cnt      <= '0;
            y_cnt      <= '0;
            mem_hcount <= block_addr(block_x, 3'd0);
            mem_vcount <= block_addr(block_y, 3'd0);
            mem_data   <= pixel_at(pixels, 4'd0);
            state      <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (mem_ready) begin
            if (last_wr) begin
              state <= S_DONE;
            end else begin
              x_cnt      <= x_nxt;
              y_cnt      <= y_nxt;
              mem_hcount <= block_addr(bx_q, x_nxt);
              mem_vcount <= block_addr(by_q, y_nxt);
              // 2x2 replication: memory (x,y) maps to source (x/2, y/2)
              mem_data   <= pixel_at(pix_q, {y_nxt[2:1], x_nxt[2:1]});
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_we = (state == S_WRITE);
  assign busy   = (state == S_WRITE);
  assign done   = (state == S_DONE);

endmodule

// File: tb/tb_store_pixel_block.sv
module tb_store_pixel_block;
  localparam int PW = 9;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         block_x;
  logic [7:0]         block_y;
  logic [16*PW-1:0]   pixels;
  logic               mem_ready;
  logic [9:0]         mem_hcount;
  logic [9:0]         mem_vcount;
  logic [PW-1:0]      mem_data;
  logic               mem_we;
  logic               busy;
  logic               done;

  store_pixel_block #(.PIXEL_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .block_x    (block_x),
    .block_y    (block_y),
    .pixels     (pixels),
    .mem_ready  (mem_ready),
    .mem_hcount (mem_hcount),
    .mem_vcount (mem_vcount),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]    h;
    logic [9:0]    v;
    logic [PW-1:0] d;
  } wr_t;

  wr_t             exp_q[$];
  int              done_q[$];
  logic [PW-1:0]   img[int];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;

  int acc_in_block = 0;
  int last_acc_cyc = -10;
  int first_we_cyc = -1;
  int first_h      = -1;
  int first_v      = -1;
  int done_cyc     = -1;
  logic pend = 1'b0;
  wr_t  pend_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ready pattern: 0 = always, 1 = every other cycle, 2 = random
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ~mem_ready;
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    wr_t w;
    wr_t e;
    if (mem_we === 1'b1) begin
      w = '{h: mem_hcount, v: mem_vcount, d: mem_data};
      if (pend) chk("stall_hold", w, pend_w);
      if (acc_in_block == 0 && !pend) begin
        first_we_cyc = cyc;
        first_h      = int'(mem_hcount);
        first_v      = int'(mem_vcount);
      end
      chk("busy_in_write", busy, 1);
      if (mem_ready) begin
        chk("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_hcount", mem_hcount, e.h);
          chk("wr_vcount", mem_vcount, e.v);
          chk("wr_data", mem_data, e.d);
        end
        img[int'(mem_vcount) * 1024 + int'(mem_hcount)] = mem_data;
        acc_in_block++;
        last_acc_cyc = cyc;
        pend = 1'b0;
      end else begin
        pend   = 1'b1;
        pend_w = w;
      end
    end
    if (done === 1'b1) begin
      done_cyc = cyc;
      chk("done_expected", done_q.size() > 0, 1);
      if (done_q.size() > 0) begin
        void'(done_q.pop_front());
        chk("writes_per_block", acc_in_block, 64);
        chk("done_after_last", cyc, last_acc_cyc + 1);
      end
      acc_in_block = 0;
    end
    if (reset === 1'b1) begin
      acc_in_block = 0;
      pend = 1'b0;
    end
  end

  function automatic logic [16*PW-1:0] rand_pix();
    logic [16*PW-1:0] p;
    for (int n = 0; n < 16; n++) p[n*PW +: PW] = PW'($urandom);
    return p;
  endfunction

  // Reference: 8x8 memory square, each memory pixel (c,r) shows source (c/2, r/2).
  task automatic push_block(input int bx, input int by, input logic [16*PW-1:0] pix);
    wr_t e;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        e.h = 10'((bx * 8 + c) % 1024);
        e.v = 10'((by * 8 + r) % 1024);
        e.d = pix[((r / 2) * 4 + c / 2) * PW +: PW];
        exp_q.push_back(e);
      end
    done_q.push_back(1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t0;

  task automatic issue(input int bx, input int by, input logic [16*PW-1:0] pix, input bit hold);
    block_x = 8'(bx);
    block_y = 8'(by);
    pixels  = pix;
    start   = 1'b1;
    push_block(bx, by, pix);
    tick();
    t0 = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_within_budget", got, 1);
    tick();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [16*PW-1:0] pix_n;
    int prev_done;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16*PW-1:0] pix_n;
    int prev_done;
    int bx, by;

    reset = 1'b1; start = 1'b0; block_x = '0; block_y = '0; pixels = '0;
    repeat (3) tick();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hcount", mem_hcount, 0);
    chk("rst_vcount", mem_vcount, 0);
    chk("rst_data", mem_data, 0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_no_start", mem_we, 0);

    // directed block, pixel n = n, memory always ready
    for (int n = 0; n < 16; n++) pix_n[n*PW +: PW] = PW'(n);
    img.delete();
    issue(2, 1, pix_n, 1'b0);
    wait_done(200);
    chk("first_write_cycle1", first_we_cyc, t0);
    chk("done_cycle65", done_cyc, t0 + 64);
    chk("img_17_9", img[9 * 1024 + 17], 0);
    chk("img_18_8", img[8 * 1024 + 18], 1);
    chk("img_23_15", img[15 * 1024 + 23], 15);
    chk("img_16_8", img[8 * 1024 + 16], 0);
    chk("img_22_12", img[12 * 1024 + 22], 11);
    chk("idle_we", mem_we, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold_h", mem_hcount, 23);
    chk("idle_hold_v", mem_vcount, 15);
    chk("idle_hold_d", mem_data, 15);

    // same block, memory ready every other cycle
    ready_mode = 1;
    tick();
    issue(2, 1, pix_n, 1'b0);
    wait_done(400);

    // address wrap past 10 bits
    ready_mode = 0;
    tick();
    issue(130, 0, rand_pix(), 1'b0);
    wait_done(200);
    chk("wrap_first_h", first_h, 16);
    chk("wrap_first_v", first_v, 0);

    // start held high: back-to-back blocks, inputs scrambled mid-block
    tick();
    issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rand_pix(), 1'b1);
    prev_done = -100;
    for (int b = 0; b < 3; b++) begin
      repeat (20) tick();
      block_x = 8'($urandom);
      block_y = 8'($urandom);
      pixels  = rand_pix();
      if (b == 2) start = 1'b0;
      wait_done(200);
      if (b > 0) chk("b2b_gap", first_we_cyc, prev_done + 2);
      prev_done = done_cyc;
      if (b < 2) begin
        bx = int'($urandom_range(0, 255));
        by = int'($urandom_range(0, 255));
        pix_n = rand_pix();
        block_x = 8'(bx);
        block_y = 8'(by);
        pixels  = pix_n;
        push_block(bx, by, pix_n);
      end
    end

    // reset at the 10th write aborts the block
    tick();
    issue(5, 3, rand_pix(), 1'b0);
    repeat (9) tick();
    chk("tenth_write_present", mem_we, 1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    exp_q.delete();
    done_q.delete();
    chk("abort_mem_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hcount", mem_hcount, 0);
    chk("abort_vcount", mem_vcount, 0);
    chk("abort_data", mem_data, 0);
    tick();
    chk("reset_over_start", mem_we, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (80) tick();
    ready_mode = 2;
    issue(5, 3, rand_pix(), 1'b0);
    wait_done(1000);
    chk("restart_first_h", first_h, 40);
    chk("restart_first_v", first_v, 24);

    // random blocks with random memory stalls, pixels scrambled mid-block
    for (int b = 0; b < 4; b++) begin
      tick();
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rand_pix(), 1'b0);
      repeat (30) tick();
      pixels  = rand_pix();
      block_x = 8'($urandom);
      wait_done(1000);
    end

    repeat (5) tick();
    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_done_q_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
